// File: rtl/seg7_ctrl.sv
// seg7_ctrl
//   Memory-mapped seven-segment display responder on the DLX data bus.
//   One 6-bit register per digit {blank, dp, hex}; registers are
//   time-multiplexed onto a shared active-low segment bus with per-digit
//   active-low anode enables. Every selected access is acknowledged one
//   cycle after it is sampled.
//
//   Bus handshake: cs is sampled on every rising edge; cs=1 at edge k gives
//   ack=1 for exactly the cycle after edge k, with rdata valid in that same
//   cycle. There is no back-pressure, so an access may be issued every cycle.
//
//   Optional feature macro: SEG7_READBACK_EN (defined = register readback,
//   undefined = rdata tied to 0).
//
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   cs       chip-select from the address decoder
//   we       1 = write, 0 = read (only meaningful with cs=1)
//   address  word address; digit i lives at BASE_ADDR + i
//   wdata    [3:0] hex value, [4] decimal point, [5] blank
//   rdata    registered read data
//   ack      one-cycle access acknowledge
//   seg      segments a..g ([0]=a), active-low
//   dp       decimal point, active-low
//   an       digit anode enables, active-low
module seg7_ctrl #(
  parameter int N_DIGITS    = 6,
  parameter int BASE_ADDR   = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cs,
  input  logic                we,
  input  logic [31:0]         address,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ack,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [5:0] BLANK = 6'b100000;

  // Active-low hex font, seg[0] = segment a.
  function automatic logic [6:0] hex_font(input logic [3:0] h);
    case (h)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  logic [5:0]          digit_q [N_DIGITS];
  logic [5:0]          digit_d [N_DIGITS];
  logic                ack_q, ack_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  // Index is computed at full width so addresses below BASE_ADDR wrap to a
  // huge value and fall out of range.
  logic [31:0]   idx;
  logic          in_range;
  logic [SW-1:0] digit_idx;
  logic [5:0]    cur;
  logic          wrap;

  // Upper write-data bits carry no meaning for this block.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:6];

  assign idx       = address - 32'(BASE_ADDR);
  assign in_range  = (address >= 32'(BASE_ADDR)) && (idx < 32'(N_DIGITS));
  assign digit_idx = idx[SW-1:0];
  assign cur       = digit_q[scan_q];
  assign wrap      = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) digit_d[i] = digit_q[i];
    if (cs && we && in_range) digit_d[digit_idx] = wdata[5:0];

    ack_d = cs;

    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    scan_d = scan_q;
    if (wrap) scan_d = (scan_q == SW'(N_DIGITS - 1)) ? '0 : scan_q + SW'(1);

    // Slot cycle 0 keeps every anode off as a ghosting guard.
    an_d = '1;
    if (cnt_q != '0) an_d[scan_q] = 1'b0;

    seg_d = cur[5] ? 7'h7F : hex_font(cur[3:0]);
    dp_d  = cur[5] | ~cur[4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_DIGITS; i++) digit_q[i] <= BLANK;
      ack_q  <= 1'b0;
      cnt_q  <= '0;
      scan_q <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) digit_q[i] <= digit_d[i];
      ack_q  <= ack_d;
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign ack = ack_q;
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

`ifdef SEG7_READBACK_EN
  logic [31:0] rdata_q, rdata_d;

  // rdata only changes on reads, so it holds across writes and idle cycles.
  always_comb begin
    rdata_d = rdata_q;
    if (cs && !we) rdata_d = in_range ? {26'b0, digit_q[digit_idx]} : 32'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`else
  assign rdata = '0;
`endif

endmodule

// File: doc/seg7_ctrl.md
# seg7_ctrl

Memory-mapped seven-segment display responder on the DLX data bus. It answers accesses that arrive with its chip-select asserted; in the default map that is word addresses 3..8, one per digit. It holds one register per digit and time-multiplexes those registers onto a shared active-low segment bus with per-digit anode enables. It acknowledges every selected access with a one-cycle handshake and optionally supports register readback.

## Interface
Parameters:
- N_DIGITS, 6, number of digits and digit registers (1..8)
- BASE_ADDR, 3, word address of digit 0
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>= 2)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cs  input  1  chip-select from the address decoder
- we  input  1  1 = write, 0 = read; sampled only when cs=1
- address  input  32  word address
- wdata  input  32  write data; [3:0] hex value, [4] decimal point, [5] blank
- rdata  output  32  registered read data
- ack  output  1  one-cycle access acknowledge
- seg  output  7  segments a..g, [0]=a, active-low
- dp  output  1  decimal point, active-low
- an  output  N_DIGITS  digit anode enables, active-low

## Operation
- Storage: digit_reg[i], 6 bits {blank, dp, hex}. Reset value is 6'b100000 (blank).
- Index: idx = address - BASE_ADDR, computed at 32 bits unsigned. An access is in range when address >= BASE_ADDR and idx < N_DIGITS.
- Write (cs=1, we=1, in range): digit_reg[idx] <= wdata[5:0]. Bits [31:6] are ignored.
- Read (cs=1, we=0): rdata <= {26'b0, digit_reg[idx]}. Readback depends on the macro; see Configuration.
- Out of range with cs=1: the write is dropped, a read returns 0, and ack is still given.
- Access pacing: an access may be issued every cycle, including back-to-back accesses to the same digit. A read that directly follows a write to the same digit returns the new value.
- Scan:
  - A counter runs 0..REFRESH_DIV-1. On wrap, the scan index advances 0..N_DIGITS-1 and then back to 0.
  - Slot cycle 0 is a blanking guard: an = all 1s.
  - In slot cycles 1..REFRESH_DIV-1, an[scan] = 0 and all other anodes are 1.
- Segment decode of digit_reg[scan]:
  - Standard hex font, 0..9 and A b C d E F.
  - seg[6:0] patterns, active-low: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E.
  - When blank=1: seg = 7'h7F and dp = 1.
  - Otherwise dp = ~dp_bit.
- Writes to the currently scanned digit appear on seg in the cycle after the register update.

## Timing
- Reset: asynchronous assert, synchronous release. While reset_n=0 and on release, all outputs are held at:
  - an = all 1s, seg = 7'h7F, dp = 1, rdata = 0, ack = 0
  - refresh counter = 0, scan = 0
- Reset mid-access: any pending ack is dropped; no register is corrupted beyond its reset value.
- Handshake:
  - cs sampled high at edge k gives ack = 1 for exactly the cycle after edge k.
  - rdata is valid in that same cycle.
  - rdata holds its value until the next read.
- Write latency: the register is updated at edge k and is visible to a read issued at edge k+1.
- Display outputs (seg, dp, an) are registered, so they lag the scan state by one cycle.
- One full refresh frame lasts N_DIGITS × REFRESH_DIV cycles.
- Simultaneous events: a write to digit i during the slot in which digit i is displayed takes effect mid-slot. No tearing protection is applied.

## Configuration
- SEG7_READBACK_EN
  - Defined: reads return {26'b0, digit_reg[idx]}, or 0 when out of range.
  - Undefined: rdata is tied to 0, the read mux is removed, and ack behaviour is unchanged.

## Test plan
- Reset check: hold reset_n=0 for 5 cycles, then release. Required: an=6'h3F, seg=7'h7F, dp=1, ack=0. After N_DIGITS×REFRESH_DIV cycles, seg is still 7'h7F.
- Write then read: write address 3 with wdata=0x15, then read address 3 on the next cycle. Required: ack=1 one cycle after each access, and rdata=0x15 (or 0 without SEG7_READBACK_EN).
- Scan check, with REFRESH_DIV=4: write digit 2 with value 0x08. When an=6'b111011, required seg=7'h00 and dp=1. The guard cycle (an=6'h3F) precedes every slot.
- Out of range: write address 9 (idx 6) with 0x01, then read address 9. Required: ack is given for both, rdata=0, and all digit registers are unchanged.
- Back-to-back: four consecutive writes to addresses 3,4,5,3 with values 1,2,3,4. Required: four ack pulses on consecutive cycles, and digit_reg[0]=4.
- Mid-scan reset: assert reset_n during slot 3. Required: an=6'h3F and seg=7'h7F immediately (asynchronous). After release, the scan restarts at digit 0 with a guard cycle.
